// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings: FSM states, opcodes and datapath select codes
// used by the control unit, the ALU control and the datapath.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM: Moore strobes per state, one state per cycle.
// FETCH/MEM_RD/MEM_WR hold (strobes stable) until mem_ready; TRAP absorbs until reset.
module mc_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_t             r_state;
  state_t             w_next;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_retired;
  logic               w_retire;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYPE:     w_next = S_EXEC;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          OP_ADDI:      w_next = S_ADDI_EX;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_EXEC:     w_next = S_R_WB;
      S_ADDI_EX:  w_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  // An instruction retires when its last state hands control back to FETCH.
  assign w_retire = (w_next == S_FETCH) &&
                    (r_state inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB});

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire)         r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    branch        = 1'b0;
    jump          = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:  alu_src_b = SRCB_IMM_SH;
      S_MEM_ADDR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch        = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        jump      = 1'b1;
      end
      S_ADDI_WB: reg_write = 1'b1;
      default: ;
    endcase
  end

  assign illegal = r_illegal;
  assign retired = r_retired;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: random instruction streams and memory waits checked
// against a per-instruction cycle model; a second instance with CNT_W=4 checks wrap.
module tb_mc_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;

  always #5 clk = ~clk;

  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, branch, jump, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [31:0] retired;
  logic [3:0]  state;

  logic        d4_pc_write, d4_pc_write_cond, d4_i_or_d, d4_mem_read, d4_mem_write, d4_ir_write;
  logic        d4_mem_to_reg, d4_reg_dst, d4_reg_write, d4_alu_src_a, d4_branch, d4_jump, d4_illegal;
  logic [1:0]  d4_alu_src_b, d4_alu_op, d4_pc_source;
  logic [3:0]  d4_retired;
  logic [3:0]  d4_state;

  mc_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .branch(branch), .jump(jump), .illegal(illegal),
    .retired(retired), .state(state)
  );

  mc_control_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(d4_pc_write), .pc_write_cond(d4_pc_write_cond), .i_or_d(d4_i_or_d),
    .mem_read(d4_mem_read), .mem_write(d4_mem_write), .ir_write(d4_ir_write),
    .mem_to_reg(d4_mem_to_reg), .reg_dst(d4_reg_dst), .reg_write(d4_reg_write),
    .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op),
    .pc_source(d4_pc_source), .branch(d4_branch), .jump(d4_jump), .illegal(d4_illegal),
    .retired(d4_retired), .state(d4_state)
  );

  logic [17:0] outs;
  assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, branch, jump};

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned m_retired = 0;
  logic [5:0]  legal_ops [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected strobes for one cycle, straight from the per-state control table.
  function automatic logic [17:0] exp_out(input int st, input logic mr);
    logic pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, br, jmp;
    logic [1:0] asb, aop, psrc;
    {pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, br, jmp} = '0;
    asb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:      begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:      asb = 2'b11;
      2, 10:  begin asa = 1; asb = 2'b10; end
      3:      begin mrd = 1; iord = 1; end
      4:      begin rw = 1; m2r = 1; end
      5:      begin mwr = 1; iord = 1; end
      6:      begin asa = 1; aop = 2'b10; end
      7:      begin rw = 1; rdst = 1; end
      8:      begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; br = 1; end
      9:      begin pcw = 1; psrc = 2'b10; jmp = 1; end
      11:     rw = 1;
      default: ;
    endcase
    return {pcw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, br, jmp};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  task automatic cyc(input int st, input logic mr, input logic [5:0] opc);
    @(negedge clk);
    mem_ready = mr;
    opcode    = opc;
    #1;
    chk("state", 32'(state), 32'(st));
    chk("strobes", 32'(outs), 32'(exp_out(st, mr)));
    chk("illegal", 32'(illegal), 32'(st == 12));
    chk("retired", retired, m_retired);
    chk("retired4", 32'(d4_retired), m_retired % 16);
  endtask

  // One instruction: wf FETCH wait cycles, wm MEM_RD/MEM_WR wait cycles.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    bit legal = 1'b1;
    for (int i = 0; i < wf; i++) cyc(0, 1'b0, r6());
    cyc(0, 1'b1, r6());
    cyc(1, rb(), op);
    case (op)
      6'h00: begin cyc(6, rb(), r6()); cyc(7, rb(), r6()); end
      6'h23: begin
        cyc(2, rb(), op);
        for (int i = 0; i < wm; i++) cyc(3, 1'b0, r6());
        cyc(3, 1'b1, r6());
        cyc(4, rb(), r6());
      end
      6'h2B: begin
        cyc(2, rb(), op);
        for (int i = 0; i < wm; i++) cyc(5, 1'b0, r6());
        cyc(5, 1'b1, r6());
      end
      6'h04: cyc(8, rb(), r6());
      6'h02: cyc(9, rb(), r6());
      6'h08: begin cyc(10, rb(), r6()); cyc(11, rb(), r6()); end
      default: begin
        legal = 1'b0;
        repeat (20) cyc(12, rb(), legal_ops[$urandom_range(0, 5)]);
      end
    endcase
    if (legal) m_retired++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    mem_ready = 1'b0;
    opcode    = r6();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_strobes", 32'(outs), 32'(exp_out(0, 1'b0)));
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_retired4", 32'(d4_retired), 32'd0);
    m_retired = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] bad_op;
    reset     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    do_reset();

    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 2);
    run_instr(6'h04, 0, 0);
    run_instr(6'h02, 0, 0);
    run_instr(6'h2B, 1, 1);
    run_instr(6'h08, 2, 0);

    for (int n = 0; n < 120; n++)
      run_instr(legal_ops[$urandom_range(0, 5)],
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

    // Reset while a load is stalled in MEM_RD.
    cyc(0, 1'b1, r6());
    cyc(1, 1'b1, 6'h23);
    cyc(2, 1'b1, 6'h23);
    cyc(3, 1'b0, r6());
    do_reset();

    repeat (17) run_instr(6'h02, 0, 0);
    @(posedge clk);
    #1;
    chk("wrap4", 32'(d4_retired), 32'd1);
    chk("count17", retired, 32'd17);

    do_reset();
    run_instr(6'h00, 0, 0);
    run_instr(6'h3F, 0, 0);
    do_reset();

    do bad_op = r6(); while (bad_op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08});
    run_instr(6'h08, 0, 0);
    run_instr(bad_op, 1, 0);
    do_reset();
    run_instr(6'h2B, 0, 0);
    run_instr(6'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control FSM for the basic MIPS-style CPU. Decodes the 6-bit `opcode` from the instruction register and sequences the shared datapath (PC, IR, register file, single ALU, unified memory) through fetch/decode/execute/memory/writeback. Produces every datapath strobe and mux select, plus the `branch`/`jump` status lines exported at the CPU top level. Stalls on a memory-ready handshake, traps on illegal opcodes and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low reset
- `opcode`  in  6  IR[31:26]
- `mem_ready`  in  1  memory completes current access this cycle
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath strobes/selects
- `alu_src_b`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `alu_op`  out  2  00 add, 01 sub, 10 funct-decoded
- `pc_source`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `branch`  out  1  high in BRANCH state
- `jump`  out  1  high in JUMP state
- `illegal`  out  1  sticky illegal-opcode flag
- `retired`  out  CNT_W  retired-instruction count
- `state`  out  4  current state encoding (debug)

## Operation
- States (encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, TRAP 12.
- Opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, j 0x02, addi 0x08; anything else illegal.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next: lw/sw→MEM_ADDR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDI_EX, else→TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; lw→MEM_RD, sw→MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; →FETCH.
- MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; →R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; →FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch=1; →FETCH.
- JUMP: pc_write=1, pc_source=10, jump=1; →FETCH.
- ADDI_EX: as MEM_ADDR; →ADDI_WB. ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; →FETCH.
- TRAP: all strobes 0, illegal=1; absorbing until reset.
- Unlisted outputs 0 in every state. Outputs are Moore except ir_write/pc_write in FETCH (qualified by mem_ready).
- `retired` increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, ADDI_WB; wraps modulo 2^CNT_W.

## Timing
- reset low at an edge: state←FETCH, illegal←0, retired←0; overrides any in-progress access, including a pending memory wait.
- After reset release, first cycle is FETCH.
- Cycles per instruction with mem_ready held 1: R 4, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle of mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle; strobes held stable while waiting.
- mem_read/mem_write never asserted together; write strobes (reg_write, pc_write, ir_write, mem_write) are single-state pulses except during memory waits.
- opcode sampled only in DECODE and MEM_ADDR; IR changes elsewhere ignored.

## Structure
- Shared package `cpu_ctrl_pkg`: state encodings, opcode constants, alu_op/alu_src_b/pc_source encodings (also used by ALU control and datapath).
- Single module; no sub-module. Separate next-state and output-decode processes; `retired` counter in the same module.

## Test plan
- Reset low 3 cycles mid-MEM_RD with mem_ready=0 → state=0, illegal=0, retired=0, all strobes 0 except FETCH defaults.
- add (0x00), mem_ready=1 → states 0,1,6,7,0; reg_write=1 with reg_dst=1 in state 7 only; retired=1.
- lw (0x23) with mem_ready low 2 cycles in MEM_RD → 7 cycles total, mem_read held through wait, reg_write+mem_to_reg in MEM_WB.
- beq (0x04) then j (0x02) → branch=1 one cycle with pc_write_cond=1, pc_source=01; jump=1 one cycle with pc_source=10; retired=2.
- opcode 0x3F → DECODE→TRAP, illegal=1, no strobes for 20 cycles, retired unchanged; reset clears.
- CNT_W=4, 17 back-to-back j instructions → retired wraps to 1.
